// File: rtl/pipelined_cpa_pkg.sv
// Shared helpers for the pipelined carry-propagate adder: slice sizing and
// elaboration-time parameter legality.
package pipelined_cpa_pkg;

    function automatic int ceil_div(input int n, input int d);
        return (n + d - 1) / d;
    endfunction

    // Width of the top slice once the lower slices take ceil_div bits each.
    function automatic int last_width(input int width, input int stages);
        return width - (stages - 1) * ceil_div(width, stages);
    endfunction

    function automatic bit params_ok(input int width, input int stages);
        return (width >= 4) && (width <= 64) &&
               (stages >= 1) && (stages <= 8) && (stages <= width) &&
               (last_width(width, stages) >= 1);
    endfunction

endpackage

// File: rtl/pipelined_cpa_slice.sv
// Combinational ripple generate/propagate adder for one pipeline slice.
module cpa_slice #(
    parameter int SW = 8
) (
    input  logic [SW-1:0] a,
    input  logic [SW-1:0] b,
    input  logic          cin,
    output logic [SW-1:0] sum,
    output logic          cout,
    output logic          cmsb
);

    logic [SW-1:0] g;
    logic [SW-1:0] p;
    logic [SW:0]   c;

    assign g = a & b;
    assign p = a ^ b;

    always_comb begin
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < SW; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
    end

    assign sum  = p ^ c[SW-1:0];
    assign cout = c[SW];
    assign cmsb = c[SW-1];

endmodule

// File: rtl/pipelined_cpa.sv
// Carry-propagate adder/subtractor split into STAGES slices, one slice per
// pipeline stage, with per-stage valid bits and bubble-collapsing flow control.
module pipelined_cpa
    import pipelined_cpa_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = ceil_div(WIDTH, STAGES);
    localparam int LW = last_width(WIDTH, STAGES);

    if (!params_ok(WIDTH, STAGES)) begin : g_bad_params
        $error("pipelined_cpa: illegal WIDTH/STAGES combination");
    end

    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] adv;
    logic [STAGES-1:0] free;
    logic [STAGES-1:0] load;
    logic              down_free;

    logic [WIDTH-1:0] a_in [STAGES];
    logic [WIDTH-1:0] b_in [STAGES];
    logic [WIDTH-1:0] s_in [STAGES];
    logic [WIDTH-1:0] s_nx [STAGES];
    logic             c_in [STAGES];
    logic             c_nx [STAGES];
    logic             cm_nx [STAGES];

    logic [WIDTH-1:0] a_q [STAGES];
    logic [WIDTH-1:0] b_q [STAGES];
    logic [WIDTH-1:0] s_q [STAGES];
    logic             c_q [STAGES];
    logic             cm_q;

    // Walk from the output back: a stage is free if empty or its successor can take its beat.
    always_comb begin
        adv       = '0;
        free      = '0;
        load      = '0;
        down_free = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            adv[k]    = v_q[k] & down_free;
            free[k]   = ~v_q[k] | down_free;
            down_free = free[k];
        end
        load[0] = in_valid & free[0];
        for (int k = 1; k < STAGES; k++) begin
            load[k] = adv[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO = k * CW;
        localparam int SW = (k == STAGES - 1) ? LW : CW;
        localparam logic [WIDTH-1:0] MASK = ((WIDTH'(1) << SW) - WIDTH'(1)) << LO;

        logic [SW-1:0] sl;

        if (k == 0) begin : g_head
            assign a_in[k] = a;
            assign b_in[k] = b ^ {WIDTH{sub}};
            assign s_in[k] = '0;
            assign c_in[k] = cin;
        end else begin : g_body
            assign a_in[k] = a_q[k-1];
            assign b_in[k] = b_q[k-1];
            assign s_in[k] = s_q[k-1];
            assign c_in[k] = c_q[k-1];
        end

        cpa_slice #(.SW(SW)) u_slice (
            .a    (a_in[k][LO +: SW]),
            .b    (b_in[k][LO +: SW]),
            .cin  (c_in[k]),
            .sum  (sl),
            .cout (c_nx[k]),
            .cmsb (cm_nx[k])
        );

        assign s_nx[k] = (s_in[k] & ~MASK) | (WIDTH'(sl) << LO);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (load[k]) begin
                    v_q[k] <= 1'b1;
                end else if (adv[k]) begin
                    v_q[k] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < STAGES; k++) begin
            if (load[k]) begin
                a_q[k] <= a_in[k];
                b_q[k] <= b_in[k];
                s_q[k] <= s_nx[k];
                c_q[k] <= c_nx[k];
            end
        end
        if (load[STAGES-1]) begin
            cm_q <= cm_nx[STAGES-1];
        end
    end

    assign in_ready  = free[0];
    assign out_valid = v_q[STAGES-1];
    assign sum       = s_q[STAGES-1];
    assign cout      = c_q[STAGES-1];
    assign ovf       = c_q[STAGES-1] ^ cm_q;

endmodule

// File: tb/tb_pipelined_cpa.sv
// Directed and randomised checks of pipelined_cpa (32/4, 13/3 and 13/1 configurations).
module tb_pipelined_cpa;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
    logic [31:0] a, b, sum;

    logic        s_valid, s_ready, s_cin, s_sub;
    logic [12:0] s_a, s_b;
    logic        t3_in_ready, t3_out_valid, t3_cout, t3_ovf;
    logic        t1_in_ready, t1_out_valid, t1_cout, t1_ovf;
    logic [12:0] t3_sum, t1_sum;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipelined_cpa #(.WIDTH(32), .STAGES(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
    );

    pipelined_cpa #(.WIDTH(13), .STAGES(3)) u_dut13_3 (
        .clk(clk), .rst_n(rst_n), .in_valid(s_valid), .in_ready(t3_in_ready),
        .a(s_a), .b(s_b), .cin(s_cin), .sub(s_sub), .out_valid(t3_out_valid),
        .out_ready(s_ready), .sum(t3_sum), .cout(t3_cout), .ovf(t3_ovf)
    );

    pipelined_cpa #(.WIDTH(13), .STAGES(1)) u_dut13_1 (
        .clk(clk), .rst_n(rst_n), .in_valid(s_valid), .in_ready(t1_in_ready),
        .a(s_a), .b(s_b), .cin(s_cin), .sub(s_sub), .out_valid(t1_out_valid),
        .out_ready(s_ready), .sum(t1_sum), .cout(t1_cout), .ovf(t1_ovf)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: {cout, ovf, sum}
    function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y,
                                          input logic c, input logic s);
        logic [31:0] ye;
        logic [32:0] f;
        logic        v;
        ye = s ? ~y : y;
        f  = {1'b0, x} + {1'b0, ye} + {32'd0, c};
        v  = (x[31] == ye[31]) && (f[31] != x[31]);
        return {f[32], v, f[31:0]};
    endfunction

    task automatic run_vec(input string tag, input logic [31:0] va, input logic [31:0] vb,
                           input logic vc, input logic vs, input logic [31:0] esum,
                           input logic ecout, input logic eovf);
        int lat;
        a = va; b = vb; cin = vc; sub = vs; in_valid = 1'b1; out_ready = 1'b1;
        #1 check({tag, "_in_ready"}, in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, lat, 4);
        check({tag, "_sum"}, sum, esum);
        check({tag, "_cout"}, cout, ecout);
        check({tag, "_ovf"}, ovf, eovf);
        @(negedge clk);
    endtask

    task automatic run13(input string tag, input logic [12:0] va, input logic [12:0] vb,
                         input logic vc, input logic vs, input logic [12:0] esum,
                         input logic ecout);
        s_a = va; s_b = vb; s_cin = vc; s_sub = vs; s_valid = 1'b1; s_ready = 1'b1;
        @(negedge clk);
        s_valid = 1'b0;
        check({tag, "_s1_valid"}, t1_out_valid, 1'b1);
        check({tag, "_s1_sum"}, t1_sum, esum);
        check({tag, "_s1_cout"}, t1_cout, ecout);
        @(negedge clk);
        check({tag, "_s3_early"}, t3_out_valid, 1'b0);
        @(negedge clk);
        check({tag, "_s3_valid"}, t3_out_valid, 1'b1);
        check({tag, "_s3_sum"}, t3_sum, esum);
        check({tag, "_s3_cout"}, t3_cout, ecout);
        @(negedge clk);
    endtask

    initial begin
        logic [33:0] expq[$];
        logic [33:0] hold, e;
        logic        held;
        int          acc, sent, emitted, cyc;

        a = '0; b = '0; cin = 1'b0; sub = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        s_a = '0; s_b = '0; s_cin = 1'b0; s_sub = 1'b0; s_valid = 1'b0; s_ready = 1'b1;

        repeat (2) @(negedge clk);
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_in_ready", in_ready, 1'b1);
        rst_n = 1'b1;
        @(negedge clk);

        run_vec("wrap",    32'hFFFF_FFFF, 32'd1,         1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        run_vec("sovf",    32'h7FFF_FFFF, 32'd1,         1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        run_vec("sub5_7",  32'd5,         32'd7,         1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        run_vec("subovf",  32'h8000_0000, 32'd1,         1'b1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
        run_vec("addcin",  32'h1234_5678, 32'h0F0F_0F0F, 1'b1, 1'b0, 32'h2143_6588, 1'b0, 1'b0);

        // Backpressure: pipe must fill to exactly four beats then stall.
        out_ready = 1'b0; in_valid = 1'b1; b = 32'd100; cin = 1'b0; sub = 1'b0;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            a = 32'(acc);
            #1;
            if (in_ready) acc++;
            @(negedge clk);
        end
        check("bp_accepted", acc, 4);
        check("bp_in_ready_low", in_ready, 1'b0);
        check("bp_head_sum", sum, 32'd100);
        @(negedge clk);
        check("bp_head_stable", sum, 32'd100);
        in_valid = 1'b0; out_ready = 1'b1;
        #1 check("bp_in_ready_release", in_ready, 1'b1);
        for (int j = 0; j < 4; j++) begin
            check("bp_drain_valid", out_valid, 1'b1);
            check("bp_drain_sum", sum, 32'(j + 100));
            @(negedge clk);
        end
        check("bp_empty", out_valid, 1'b0);

        // Reset with three beats in flight.
        out_ready = 1'b0; in_valid = 1'b1; b = 32'd1;
        for (int i = 0; i < 3; i++) begin
            a = 32'h10 + 32'(i);
            @(negedge clk);
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("rst_pre_valid", out_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        check("rst_async_valid", out_valid, 1'b0);
        check("rst_async_ready", in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        emitted = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) emitted++;
        end
        check("rst_discard", emitted, 0);
        run_vec("post_rst", 32'h0000_FFFF, 32'd1, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0);

        // Random stream with random backpressure.
        sent = 0; held = 1'b0; hold = '0; cyc = 0;
        while ((sent < 100 || expq.size() > 0) && cyc < 3000) begin
            out_ready = 1'($urandom_range(0, 1));
            in_valid  = (sent < 100) ? 1'($urandom_range(0, 1)) : 1'b0;
            a = $urandom; b = $urandom;
            cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
            #1;
            if (held) begin
                check("stall_valid", out_valid, 1'b1);
                check("stall_hold", {cout, ovf, sum}, hold);
            end
            if (in_valid && in_ready) begin
                expq.push_back(model(a, b, cin, sub));
                sent++;
            end
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    check("stream_extra_beat", 1'b1, 1'b0);
                end else begin
                    e = expq.pop_front();
                    check("stream_result", {cout, ovf, sum}, e);
                end
            end
            held = out_valid && !out_ready;
            hold = {cout, ovf, sum};
            @(negedge clk);
            cyc++;
        end
        check("stream_sent", sent, 100);
        check("stream_drained", expq.size(), 0);
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (5) @(negedge clk);

        // 13-bit configurations: full carry chain and a borrow across a slice boundary.
        run13("w13_chain", 13'h1FFF, 13'h0001, 1'b0, 1'b0, 13'h0000, 1'b1);
        run13("w13_sub",   13'h0020, 13'h0001, 1'b1, 1'b1, 13'h001F, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipelined_cpa.md
PIPELINED_CPA -- requirements
Module: pipelined_cpa

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32: operand/sum width in bits, legal range 4..64.
REQ-002 The block SHALL have parameter STAGES, default 4: number of pipeline stages, legal range 1..8, STAGES <= WIDTH.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: operand beat present.
REQ-006 The block SHALL have port in_ready, output, 1 bit: block accepts a beat this cycle.
REQ-007 The block SHALL have port a, input, WIDTH bits: operand A.
REQ-008 The block SHALL have port b, input, WIDTH bits: operand B.
REQ-009 The block SHALL have port cin, input, 1 bit: carry-in.
REQ-010 The block SHALL have port sub, input, 1 bit: 1 selects A - B - ~cin... see REQ-016.
REQ-011 The block SHALL have port out_valid, output, 1 bit: result beat present.
REQ-012 The block SHALL have port out_ready, input, 1 bit: downstream accepts result.
REQ-013 The block SHALL have port sum, output, WIDTH bits: result.
REQ-014 The block SHALL have port cout, output, 1 bit: carry-out of MSB.
REQ-015 The block SHALL have port ovf, output, 1 bit: two's-complement signed overflow.

Function
REQ-016 Arithmetic: sub=0 -> {cout,sum} = A + B + cin; sub=1 -> {cout,sum} = A + ~B + cin (A - B when cin=1, A - B - 1 when cin=0).
REQ-017 ovf SHALL equal carry into MSB XOR carry out of MSB.
REQ-018 Operand is split into STAGES slices of CW = ceil(WIDTH/STAGES) bits, LSB first; last slice takes the remainder (WIDTH - (STAGES-1)*CW bits, must be >= 1, else elaboration error).
REQ-019 Stage k SHALL compute slice k with a ripple generate/propagate chain seeded by the registered carry from stage k-1 (stage 0 seeded by effective cin); unprocessed slices and completed sum slices travel skewed in stage registers.
REQ-020 Latency SHALL be exactly STAGES cycles from accepted beat (in_valid & in_ready) to out_valid with no backpressure.
REQ-021 Throughput SHALL be one beat per cycle when out_ready is held high.
REQ-022 Each stage holds a valid bit; stage k advances when its successor is empty or advancing (bubble collapsing); the last stage advances on out_ready.
REQ-023 in_ready SHALL be high when stage 0 is empty or advancing; it SHALL NOT depend combinationally on in_valid.
REQ-024 sum/cout/ovf SHALL be stable while out_valid=1 and out_ready=0.
REQ-025 Beats SHALL exit in acceptance order; no beat dropped or duplicated.
REQ-026 Simultaneous accept and emit on a full pipe SHALL be legal when out_ready=1.
REQ-027 Data registers SHALL load only on advance; out_valid=0 outputs carry no meaning.

Reset
REQ-028 rst_n low SHALL asynchronously clear all stage valid bits; out_valid=0 and in_ready=1 one cycle later; data registers need no reset.
REQ-029 Reset mid-operation SHALL discard all in-flight beats; the first beat after deassertion SHALL emerge after STAGES cycles.

Structure
REQ-030 A shared package SHALL hold the slice-width function ceil_div and the parameter legality checks.
REQ-031 One sub-module cpa_slice (combinational, parameter SW: a, b, cin -> sum, cout, carry into MSB) SHALL be instantiated per stage.

Verification
REQ-032 WIDTH=32, STAGES=4: a=0xFFFFFFFF, b=1, cin=0, sub=0 -> after 4 cycles sum=0, cout=1, ovf=0.
REQ-033 WIDTH=32: a=0x7FFFFFFF, b=1, cin=0, sub=0 -> sum=0x80000000, cout=0, ovf=1; a=5, b=7, cin=1, sub=1 -> sum=0xFFFFFFFE, cout=0.
REQ-034 Streaming 100 random beats with out_ready toggled randomly -> results match reference model in order, sum held stable while stalled.
REQ-035 out_ready=0 for 6 cycles with in_valid=1 -> exactly STAGES beats accepted, then in_ready=0 until out_ready=1.
REQ-036 rst_n pulsed low with 3 beats in flight -> out_valid=0 immediately, none of the 3 ever emitted.
REQ-037 WIDTH=13, STAGES=3 (slices 5,5,3) and STAGES=1 -> exhaustive-corner carry chain 0x1FFF+1 gives sum=0, cout=1.
